// File: rtl/voting_pkg.sv
// ============================================================================
//  Module   : voting_pkg
//  Purpose  : Shared types and width helpers for the sequential voting front
//             end (state encoding, tally / candidate / ballot sizing).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package voting_pkg;

  // Election controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SCAN    = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Tally width: one extra bit so a unanimous 2**M vote fits without wrap
  function automatic int tally_width(input int m);
    return m + 1;
  endfunction

  // Number of candidates for an N-bit ballot
  function automatic int num_cand(input int n);
    return 1 << n;
  endfunction

  // Number of ballots cast per election
  function automatic int num_vote(input int m);
    return 1 << m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/voting_tally_bank.sv
// ============================================================================
//  Module   : voting_tally_bank
//  Purpose  : Register array of per-candidate tallies. Synchronous clear,
//             single-cycle increment of one entry, combinational read port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module voting_tally_bank
  import voting_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc_en,
  input  logic [N-1:0] inc_idx,
  input  logic [N-1:0] rd_idx,
  output logic [W-1:0] rd_data
);

  localparam int NCAND = num_cand(N);

  logic [W-1:0] r_tally [NCAND];

  // Clear wins over increment so a new election never inherits a stray ballot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCAND; i++) r_tally[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NCAND; i++) r_tally[i] <= '0;
    end else if (inc_en) begin
      for (int i = 0; i < NCAND; i++) begin
        if (inc_idx == N'(i)) r_tally[i] <= r_tally[i] + W'(1);
      end
    end
  end

  assign rd_data = r_tally[rd_idx];

endmodule

`default_nettype wire

// File: rtl/voting_seq_ctrl.sv
// ============================================================================
//  Module   : voting_seq_ctrl
//  Purpose  : Sequential voting front end. Accepts 2**M ballots over a
//             valid/ready handshake, tallies them per candidate, scans the
//             tallies one per cycle and presents the winner (ties -> lowest
//             index) with its count.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module voting_seq_ctrl
  import voting_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] vote,
  input  logic         vote_valid,
  output logic         vote_ready,
  output logic         busy,
  output logic         winner_valid,
  output logic [N-1:0] winner,
  output logic [M:0]   winner_count
);

  localparam int TALLY_W = tally_width(M);
  localparam int NVOTE   = num_vote(M);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_clear;
  logic                 w_accept;
  logic                 w_last_ballot;
  logic                 w_scan_end;
  logic [M:0]           r_ballot_cnt;
  logic [M:0]           w_cnt_inc;
  logic [N:0]           r_scan_idx;
  logic [N-1:0]         r_best_idx;
  logic [TALLY_W-1:0]   r_best_cnt;
  logic [TALLY_W-1:0]   w_rd_data;
  logic [N-1:0]         r_winner;
  logic [TALLY_W-1:0]   r_winner_count;

  assign w_accept      = vote_valid && vote_ready;
  assign w_cnt_inc     = r_ballot_cnt + (M+1)'(1);
  assign w_last_ballot = (w_cnt_inc == (M+1)'(NVOTE));
  // Index has one spare MSB: it reaches 2**N after the last candidate
  assign w_scan_end    = r_scan_idx[N];

  voting_tally_bank #(
    .N (N),
    .W (TALLY_W)
  ) u_tally_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_clear),
    .inc_en  (w_accept),
    .inc_idx (vote),
    .rd_idx  (r_scan_idx[N-1:0]),
    .rd_data (w_rd_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake/status outputs; start is ignored while busy
  always_comb begin
    w_state_nxt  = r_state;
    vote_ready   = 1'b0;
    busy         = 1'b0;
    winner_valid = 1'b0;
    w_clear      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        vote_ready = 1'b1;
        busy       = 1'b1;
        if (vote_valid && w_last_ballot) w_state_nxt = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (w_scan_end) w_state_nxt = DONE;
      end
      DONE: begin
        winner_valid = 1'b1;
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ballot counter: cleared on election open, advanced per accepted ballot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ballot_cnt <= '0;
    else if (w_clear)  r_ballot_cnt <= '0;
    else if (w_accept) r_ballot_cnt <= w_cnt_inc;
  end

  // Max scan: strict greater-than keeps the lowest index on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_idx <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
    end else if (w_accept && w_last_ballot) begin
      r_scan_idx <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
    end else if (r_state == SCAN && !w_scan_end) begin
      if (w_rd_data > r_best_cnt) begin
        r_best_idx <= r_scan_idx[N-1:0];
        r_best_cnt <= w_rd_data;
      end
      r_scan_idx <= r_scan_idx + (N+1)'(1);
    end
  end

  // Result registers: updated only when the scan completes, so they keep the
  // previous election's values while a new one is in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_winner       <= '0;
      r_winner_count <= '0;
    end else if (r_state == SCAN && w_scan_end) begin
      r_winner       <= r_best_idx;
      r_winner_count <= r_best_cnt;
    end
  end

  assign winner       = r_winner;
  assign winner_count = r_winner_count;

endmodule

`default_nettype wire

// File: doc/voting_seq_ctrl.md
Name: voting_seq_ctrl

Overview:
Sequential front end for the voting datapath. Collects 2**M ballots one per handshake and keeps a per-candidate tally. It then scans the tallies and presents the winning candidate index to the downstream consumer.
This block replaces feeding all ballots in parallel, for flows where ballots arrive over time from a shared channel.

Parameters:
N, 2, log2 of number of candidates (2**N candidates; ballot width N)
M, 2, log2 of number of voters (exactly 2**M ballots per election)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; opens a new election when idle or done
vote  input  N  candidate index of offered ballot
vote_valid  input  1  ballot offered this cycle
vote_ready  output  1  block accepts ballot this cycle
busy  output  1  election in progress (COLLECT or SCAN)
winner_valid  output  1  winner/winner_count are valid
winner  output  N  winning candidate index
winner_count  output  M+1  tally of winning candidate

Behaviour:
- Reset (async assert, sync release): state=IDLE; all tallies, ballot counter, scan index, best index/count = 0.
- Reset values of outputs: vote_ready=0, busy=0, winner_valid=0, winner=0, winner_count=0.
- Reset mid-operation aborts the election. No partial result is ever shown.
- States: IDLE, COLLECT, SCAN, DONE.
- IDLE: start -> COLLECT. Entry clears all tallies and the ballot counter in the same edge.
- COLLECT: vote_ready=1, busy=1.
  - Ballot is accepted on an edge where vote_valid && vote_ready.
  - Acceptance increments tally[vote] and the ballot counter (width M+1).
  - On acceptance of ballot number 2**M -> SCAN, with scan index=0, best_idx=0, best_cnt=0.
  - vote_ready is 0 in every state except COLLECT.
  - A ballot offered outside COLLECT is not consumed and has no effect.
- SCAN: busy=1. One candidate per cycle, index i = 0 .. 2**N-1.
  - If tally[i] > best_cnt (strict), then best_idx<=i and best_cnt<=tally[i].
  - Ties resolve to the lowest index. All-zero is impossible because 2**M >= 1 ballots are cast.
  - After i = 2**N-1 is evaluated -> DONE.
- DONE: winner_valid=1; winner/winner_count hold the final best values; busy=0.
  - State holds until start, then -> COLLECT with tallies cleared and winner_valid dropped the same edge.
- start in COLLECT or SCAN is ignored; the election continues.
- Widths: tallies are M+1 bits, so a unanimous vote of 2**M fits without wrap.
  - Ballot counter is M+1 bits; compare against 2**M.
  - Scan index is N+1 bits, or N bits plus a last flag; it must not wrap before DONE is reached.
- Latency: from acceptance of the final ballot, winner_valid rises exactly 2**N + 1 edges later (2**N SCAN cycles plus the transition into DONE).
- Throughput: one ballot per cycle with vote_valid held high. A full election takes 1 + 2**M + 2**N + 1 cycles from start to winner_valid.
- winner/winner_count are registered outputs. They keep the previous election's values while busy, but are only meaningful when winner_valid=1.

Decomposition:
- Shared package voting_pkg:
  - state enum (IDLE, COLLECT, SCAN, DONE)
  - width localparams: TALLY_W=M+1, NCAND=2**N, NVOTE=2**M
- One natural sub-module: voting_tally_bank.
  - Register array of 2**N tallies.
  - Ports: clear, inc_en, inc_idx, rd_idx, rd_data.
  - Single-cycle increment, combinational read.
- FSM, ballot counter and max-scan stay in voting_seq_ctrl.

Test Plan:
- N=2,M=2; start; ballots 1,1,2,3 back-to-back -> vote_ready high 4 cycles; winner_valid 5 edges after last ballot; winner=1, winner_count=2.
- Tie: ballots 3,0,3,0 -> winner=0 (lowest index), winner_count=2.
- Unanimous N=2,M=2: ballots 3,3,3,3 -> winner=3, winner_count=4 (no wrap). Repeat with N=1,M=4: sixteen 1s -> winner=1, winner_count=16.
- Gaps/backpressure: vote_valid toggled 1,0,1,0...; ballot offered during SCAN and DONE; start pulsed mid-COLLECT -> only COLLECT handshakes counted; result matches the 4 accepted ballots; election not restarted.
- rst_n pulsed low after 2 ballots -> outputs 0 immediately (async); new start plus 4 ballots 2,2,2,0 -> winner=2, winner_count=3 (no stale tallies).
- Back-to-back elections: after DONE (winner=1), start -> winner_valid drops next edge; second election ballots 0,0,0,1 -> winner=0, winner_count=3.
